// File: rtl/iod_dly_pkg.sv
// iod_dly_pkg: shared op, status and sequencer state encodings for the IOD delay-line controller
package iod_dly_pkg;
  typedef enum logic [1:0] {OP_LOAD, OP_INC, OP_DEC, OP_RSVD} op_e;
  typedef enum logic [1:0] {ST_OK, ST_RANGE, ST_BAD_CMD} status_e;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SETUP, S_MOVE, S_GAP, S_LOAD, S_DONE} state_e;
endpackage

// File: rtl/iod_delay_line_ctrl_if.sv
// iod_delay_line_ctrl_if: command/response port between training logic and the delay-line sequencer
interface iod_delay_line_ctrl_if #(
  parameter int NUM_LANES = 8,
  parameter int TAP_W = 7
);
  localparam int LANE_W = $clog2(NUM_LANES);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [LANE_W-1:0] cmd_lane;
  logic [TAP_W-1:0] cmd_count;
  logic rsp_valid;
  logic [1:0] rsp_status;
  logic [TAP_W-1:0] rsp_taps;
  logic busy;
  modport master(output cmd_valid, cmd_op, cmd_lane, cmd_count,
                 input cmd_ready, rsp_valid, rsp_status, rsp_taps, busy);
  modport slave(input cmd_valid, cmd_op, cmd_lane, cmd_count,
                output cmd_ready, rsp_valid, rsp_status, rsp_taps, busy);
endinterface

// File: rtl/iod_dly_pos_bank.sv
// iod_dly_pos_bank: per-lane tap position registers with limit flags for the selected lane
module iod_dly_pos_bank #(
  parameter int NUM_LANES = 8,
  parameter int TAP_W = 7,
  parameter int TAP_MAX = 127,
  parameter int INIT_TAP = 1,
  parameter int LANE_W = $clog2(NUM_LANES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restore,
  input  logic step,
  input  logic up,
  input  logic [LANE_W-1:0] sel,
  output logic [NUM_LANES*TAP_W-1:0] pos_flat,
  output logic [TAP_W-1:0] sel_pos,
  output logic at_max,
  output logic at_zero
);
  logic [TAP_W-1:0] pos [NUM_LANES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_LANES; i++) pos[i] <= TAP_W'(INIT_TAP);
    else if (restore) pos[sel] <= TAP_W'(INIT_TAP);
    else if (step) pos[sel] <= up ? pos[sel] + 1'b1 : pos[sel] - 1'b1;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_pos
    assign pos_flat[i*TAP_W +: TAP_W] = pos[i];
  end
  assign sel_pos = pos[sel];
  assign at_max = sel_pos == TAP_W'(TAP_MAX);
  assign at_zero = sel_pos == '0;
endmodule

// File: rtl/iod_delay_line_ctrl.sv
// iod_delay_line_ctrl: sequences LOAD/INC/DEC-by-N commands into spaced per-lane IOD delay-line pulses
module iod_delay_line_ctrl
  import iod_dly_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int TAP_W = 7,
  parameter int TAP_MAX = 127,
  parameter int INIT_TAP = 1,
  parameter int GAP_CYCLES = 4
) (
  input  logic FAB_CLK,
  input  logic ARST_N,
  iod_delay_line_ctrl_if.slave cmd,
  output logic [NUM_LANES*TAP_W-1:0] TAP_POS,
  output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE
);
  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int GW = $clog2(GAP_CYCLES);
  state_e state, nxt;
  status_e st_nxt;
  op_e op_q;
  logic [LANE_W-1:0] lane_q;
  logic [TAP_W-1:0] cnt_q, moved, moved_nxt, sel_pos;
  logic [GW-1:0] gap;
  logic [NUM_LANES-1:0] oor_q, lane_hot;
  logic accept, inc, at_max, at_zero, blocked, edge_hit, gap_last, step, restore;
  assign accept = state == S_IDLE && cmd.cmd_valid && cmd.cmd_ready;
  assign inc = op_q == OP_INC;
  assign blocked = inc ? at_max : at_zero;
  // the step taken this cycle lands on the limit, so the next move's pre-check must fail
  assign edge_hit = inc ? sel_pos == TAP_W'(TAP_MAX - 1) : sel_pos == TAP_W'(1);
  assign gap_last = gap == '0;
  assign lane_hot = NUM_LANES'(1) << lane_q;
  iod_dly_pos_bank #(
    .NUM_LANES(NUM_LANES), .TAP_W(TAP_W), .TAP_MAX(TAP_MAX), .INIT_TAP(INIT_TAP), .LANE_W(LANE_W)
  ) u_bank (
    .clk(FAB_CLK), .rst_n(ARST_N), .restore(restore), .step(step), .up(inc), .sel(lane_q),
    .pos_flat(TAP_POS), .sel_pos(sel_pos), .at_max(at_max), .at_zero(at_zero)
  );
  always_comb begin
    nxt = state;
    st_nxt = ST_OK;
    moved_nxt = moved;
    step = 1'b0;
    restore = 1'b0;
    case (state)
      S_IDLE: nxt = accept ? S_CHECK : S_IDLE;
      S_CHECK: begin
        if (op_q == OP_RSVD || int'(lane_q) >= NUM_LANES) begin
          nxt = S_DONE;
          st_nxt = ST_BAD_CMD;
        end else if (op_q == OP_LOAD) nxt = S_LOAD;
        else nxt = cnt_q == '0 ? S_DONE : S_SETUP;
      end
      S_SETUP: begin
        nxt = blocked ? S_DONE : S_MOVE;
        st_nxt = blocked ? ST_RANGE : ST_OK;
      end
      S_MOVE, S_LOAD: nxt = S_GAP;
      S_GAP: if (gap_last) begin
        if (op_q == OP_LOAD) begin
          restore = 1'b1;
          nxt = S_DONE;
        end else if (oor_q[lane_q]) begin
          nxt = S_DONE;
          st_nxt = ST_RANGE;
        end else begin
          step = 1'b1;
          moved_nxt = moved + 1'b1;
          nxt = (moved_nxt == cnt_q || edge_hit) ? S_DONE : S_MOVE;
          st_nxt = (moved_nxt != cnt_q && edge_hit) ? ST_RANGE : ST_OK;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge FAB_CLK or negedge ARST_N)
    if (!ARST_N) begin
      state <= S_IDLE;
      op_q <= OP_LOAD;
      lane_q <= '0;
      cnt_q <= '0;
      moved <= '0;
      gap <= '0;
      oor_q <= '0;
      cmd.cmd_ready <= 1'b0;
      cmd.busy <= 1'b0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_status <= ST_OK;
      cmd.rsp_taps <= '0;
      DELAY_LINE_MOVE <= '0;
      DELAY_LINE_LOAD <= '0;
      DELAY_LINE_DIRECTION <= '0;
    end else begin
      state <= nxt;
      moved <= accept ? '0 : moved_nxt;
      if (accept) begin
        op_q <= op_e'(cmd.cmd_op);
        lane_q <= cmd.cmd_lane;
        cnt_q <= cmd.cmd_count;
      end
      gap <= state == S_GAP ? gap - 1'b1 : GW'(GAP_CYCLES - 1);
      oor_q <= DELAY_LINE_OUT_OF_RANGE;
      cmd.cmd_ready <= nxt == S_IDLE;
      cmd.busy <= nxt != S_IDLE;
      cmd.rsp_valid <= nxt == S_DONE;
      cmd.rsp_status <= nxt == S_DONE ? st_nxt : ST_OK;
      cmd.rsp_taps <= nxt == S_DONE ? moved_nxt : '0;
      DELAY_LINE_MOVE <= nxt == S_MOVE ? lane_hot : '0;
      DELAY_LINE_LOAD <= nxt == S_LOAD ? lane_hot : '0;
      if (nxt == S_SETUP) DELAY_LINE_DIRECTION[lane_q] <= inc;
    end
endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
// tb_iod_delay_line_ctrl: randomized and directed checks of the delay-line sequencer against a command-level model
module tb_iod_delay_line_ctrl;
  localparam int NL = 6, TW = 7, TMAX = 127, INIT = 1, GAP = 4, LW = $clog2(NL);
  typedef struct packed {
    logic [15:0] n_mv;
    logic [31:0] mv_sum;
    logic [15:0] mv_last;
    logic [15:0] n_ld;
    logic [15:0] ld_k;
    logic [15:0] rsp_k;
    logic [1:0] st;
    logic [TW-1:0] taps;
  } res_t;
  logic FAB_CLK = 1'b0;
  logic ARST_N = 1'b0;
  logic [NL*TW-1:0] tap_pos;
  logic [NL-1:0] mv, dir, ld;
  logic [NL-1:0] oor = '0;
  int checks = 0, errors = 0;
  int mpos [NL];
  logic [NL-1:0] mdir = '0;
  iod_delay_line_ctrl_if #(.NUM_LANES(NL), .TAP_W(TW)) bus();
  iod_delay_line_ctrl #(
    .NUM_LANES(NL), .TAP_W(TW), .TAP_MAX(TMAX), .INIT_TAP(INIT), .GAP_CYCLES(GAP)
  ) dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .cmd(bus), .TAP_POS(tap_pos),
    .DELAY_LINE_MOVE(mv), .DELAY_LINE_DIRECTION(dir), .DELAY_LINE_LOAD(ld),
    .DELAY_LINE_OUT_OF_RANGE(oor)
  );
  always #5 FAB_CLK = ~FAB_CLK;

  function automatic logic [NL*TW-1:0] exp_pos();
    logic [NL*TW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*TW +: TW] = TW'(mpos[i]);
    return v;
  endfunction

  // command-level model: cycle offsets are counted from the accepting edge
  task automatic predict(input logic [1:0] op, input int lane, input int cnt, input int oor_m, output res_t e);
    int p, nm;
    e = '0;
    if (op == 2'b11 || lane >= NL) begin
      e.rsp_k = 16'd2;
      e.st = 2'b10;
    end else if (op == 2'b00) begin
      e.n_ld = 16'd1;
      e.ld_k = 16'd2;
      e.rsp_k = 16'(3 + GAP);
      mpos[lane] = INIT;
    end else if (cnt == 0) e.rsp_k = 16'd2;
    else begin
      mdir[lane] = op == 2'b01;
      p = mpos[lane];
      nm = 0;
      for (int m = 1; m <= cnt; m++) begin
        if (op == 2'b01 ? p == TMAX : p == 0) begin
          e.st = 2'b01;
          break;
        end
        nm++;
        e.n_mv = 16'(nm);
        e.mv_sum = e.mv_sum + 32'(3 + (m - 1) * (GAP + 1));
        e.mv_last = 16'(3 + (m - 1) * (GAP + 1));
        if (m == oor_m) begin
          e.st = 2'b01;
          break;
        end
        p = p + (op == 2'b01 ? 1 : -1);
        e.taps = e.taps + 1'b1;
      end
      mpos[lane] = p;
      e.rsp_k = 16'(3 + nm * (GAP + 1));
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [LW-1:0] lane, input logic [TW-1:0] cnt,
                       input int oor_m, input bit hold, output res_t o, output int stray);
    int w = 0;
    o = '0;
    stray = 0;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin
      @(negedge FAB_CLK);
      w++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_lane = lane;
    bus.cmd_count = cnt;
    @(negedge FAB_CLK);
    if (hold) begin
      bus.cmd_op = 2'($urandom);
      bus.cmd_lane = LW'($urandom);
      bus.cmd_count = TW'($urandom);
    end else bus.cmd_valid = 1'b0;
    for (int k = 1; k < 1000; k++) begin
      if (k > 1) @(negedge FAB_CLK);
      for (int i = 0; i < NL; i++) begin
        if (mv[i] && i == int'(lane)) begin
          o.n_mv = o.n_mv + 16'd1;
          o.mv_sum = o.mv_sum + 32'(k);
          o.mv_last = 16'(k);
        end else if (mv[i]) stray++;
        if (ld[i] && i == int'(lane)) begin
          o.n_ld = o.n_ld + 16'd1;
          o.ld_k = 16'(k);
        end else if (ld[i]) stray++;
      end
      if (oor_m != 0 && int'(o.n_mv) == oor_m) oor[lane] = 1'b1;
      if (bus.rsp_valid === 1'b1) begin
        o.rsp_k = 16'(k);
        o.st = bus.rsp_status;
        o.taps = bus.rsp_taps;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    oor = '0;
    checks++;
    if (o.rsp_k == 16'd0) begin
      errors++;
      $display("FAIL rsp_timeout: no rsp_valid within 1000 cycles, required one");
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_status, bus.rsp_taps, mv, dir, ld} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b busy=%b rsp=%b st=%b taps=%0d mv=%b dir=%b ld=%b required all 0",
               bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_status, bus.rsp_taps, mv, dir, ld);
    end
    checks++;
    if (tap_pos !== exp_pos()) begin
      errors++;
      $display("FAIL reset_pos: tap_pos=%h required %h", tap_pos, exp_pos());
    end
    @(negedge FAB_CLK);
    ARST_N = 1'b1;
    @(negedge FAB_CLK);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b required 1/0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_load();
    res_t o, e;
    int s;
    mpos[3] = INIT;
    predict(2'b00, 3, 0, 0, e);
    issue(2'b00, 3'd3, 7'd0, 0, 1'b0, o, s);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL load_rsp: got %h required %h", o, e);
    end
    checks++;
    if (s != 0) begin
      errors++;
      $display("FAIL load_stray: %0d stray pulses, required 0", s);
    end
    checks++;
    if (tap_pos !== exp_pos()) begin
      errors++;
      $display("FAIL load_pos: tap_pos=%h required %h", tap_pos, exp_pos());
    end
  endtask

  task automatic test_inc_hold();
    res_t o, e;
    int s;
    predict(2'b01, 0, 3, 0, e);
    issue(2'b01, 3'd0, 7'd3, 0, 1'b1, o, s);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL inc_rsp: got %h required %h", o, e);
    end
    checks++;
    if (s != 0 || dir !== mdir) begin
      errors++;
      $display("FAIL inc_pulses: stray=%0d dir=%b required 0 and %b", s, dir, mdir);
    end
    repeat (3) @(negedge FAB_CLK);
    checks++;
    if (bus.busy !== 1'b0 || tap_pos !== exp_pos()) begin
      errors++;
      $display("FAIL inc_no_reaccept: busy=%b tap_pos=%h required 0 and %h", bus.busy, tap_pos, exp_pos());
    end
  endtask

  task automatic test_dec_range();
    res_t o, e;
    int s;
    predict(2'b10, 2, 5, 0, e);
    issue(2'b10, 3'd2, 7'd5, 0, 1'b0, o, s);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL dec_range_rsp: got %h required %h", o, e);
    end
    checks++;
    if (s != 0 || dir !== mdir || tap_pos !== exp_pos()) begin
      errors++;
      $display("FAIL dec_range_state: stray=%0d dir=%b pos=%h required 0 %b %h", s, dir, tap_pos, mdir, exp_pos());
    end
  endtask

  task automatic test_oor();
    res_t o, e;
    int s;
    predict(2'b01, 5, 10, 2, e);
    issue(2'b01, 3'd5, 7'd10, 2, 1'b0, o, s);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL oor_rsp: got %h required %h", o, e);
    end
    checks++;
    if (s != 0 || dir !== mdir || tap_pos !== exp_pos()) begin
      errors++;
      $display("FAIL oor_state: stray=%0d dir=%b pos=%h required 0 %b %h", s, dir, tap_pos, mdir, exp_pos());
    end
  endtask

  task automatic test_bad_cmd();
    logic [1:0] ops [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
    logic [LW-1:0] lanes [4] = '{3'd2, 3'd7, 3'd6, 3'd1};
    logic [TW-1:0] cnts [4] = '{7'd5, 7'd4, 7'd0, 7'd0};
    res_t o, e;
    int s;
    for (int j = 0; j < 4; j++) begin
      predict(ops[j], int'(lanes[j]), int'(cnts[j]), 0, e);
      issue(ops[j], lanes[j], cnts[j], 0, j[0], o, s);
      checks++;
      if (o !== e || s != 0) begin
        errors++;
        $display("FAIL bad_cmd_%0d: got %h stray=%0d required %h stray=0", j, o, s, e);
      end
      checks++;
      if (dir !== mdir || tap_pos !== exp_pos()) begin
        errors++;
        $display("FAIL bad_cmd_state_%0d: dir=%b pos=%h required %b %h", j, dir, tap_pos, mdir, exp_pos());
      end
    end
  endtask

  task automatic test_max();
    res_t o, e;
    int s;
    for (int j = 0; j < 2; j++) begin
      predict(2'b01, 1, 127, 0, e);
      issue(2'b01, 3'd1, 7'd127, 0, 1'b0, o, s);
      checks++;
      if (o !== e || s != 0) begin
        errors++;
        $display("FAIL max_rsp_%0d: got %h stray=%0d required %h stray=0", j, o, s, e);
      end
      checks++;
      if (tap_pos !== exp_pos()) begin
        errors++;
        $display("FAIL max_pos_%0d: tap_pos=%h required %h", j, tap_pos, exp_pos());
      end
    end
  endtask

  task automatic test_random();
    res_t o, e;
    int s, om;
    logic [1:0] op;
    logic [LW-1:0] lane;
    logic [TW-1:0] cnt;
    for (int j = 0; j < 40; j++) begin
      op = 2'($urandom_range(0, 3));
      lane = LW'($urandom_range(0, 7));
      cnt = TW'($urandom_range(0, 12));
      om = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 4)) : 0;
      predict(op, int'(lane), int'(cnt), om, e);
      issue(op, lane, cnt, om, 1'($urandom), o, s);
      checks++;
      if (o !== e || s != 0) begin
        errors++;
        $display("FAIL random_%0d op=%0d lane=%0d cnt=%0d oor=%0d: got %h stray=%0d required %h stray=0",
                 j, op, lane, cnt, om, o, s, e);
      end
      checks++;
      if (dir !== mdir || tap_pos !== exp_pos()) begin
        errors++;
        $display("FAIL random_state_%0d: dir=%b pos=%h required %b %h", j, dir, tap_pos, mdir, exp_pos());
      end
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin
      @(negedge FAB_CLK);
      w++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b01;
    bus.cmd_lane = 3'd4;
    bus.cmd_count = 7'd5;
    @(negedge FAB_CLK);
    bus.cmd_valid = 1'b0;
    repeat (9) @(negedge FAB_CLK);
    checks++;
    if (tap_pos[4*TW +: TW] !== TW'(mpos[4] + 1) || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: lane4=%0d busy=%b required %0d and 1", tap_pos[4*TW +: TW], bus.busy, mpos[4] + 1);
    end
    ARST_N = 1'b0;
    for (int i = 0; i < NL; i++) mpos[i] = INIT;
    mdir = '0;
    #1;
    checks++;
    if ({mv, ld, dir, bus.rsp_valid, bus.cmd_ready, bus.busy} !== '0) begin
      errors++;
      $display("FAIL mid_abort: mv=%b ld=%b dir=%b rsp=%b ready=%b busy=%b required all 0",
               mv, ld, dir, bus.rsp_valid, bus.cmd_ready, bus.busy);
    end
    checks++;
    if (tap_pos !== exp_pos()) begin
      errors++;
      $display("FAIL mid_pos: tap_pos=%h required %h", tap_pos, exp_pos());
    end
    repeat (2) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    @(negedge FAB_CLK);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: ready=%b rsp=%b required 1 and 0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_lane = '0;
    bus.cmd_count = '0;
    for (int i = 0; i < NL; i++) mpos[i] = INIT;
    test_reset();
    test_load();
    test_inc_hold();
    test_dec_range();
    test_oor();
    test_bad_cmd();
    test_max();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
